x_input_conditioner: RTL and testbench

- Upstream stage of the `main` response FSM. Takes the raw, asynchronous, bouncing push-button/switch signal and delivers a clean, clock-synchronous `x` with no glitches.
- Chain: synchronizer, then debounce counter FSM, then output shaping. The `main` block then sees only stable 0/1 values on `x`, never metastable or bouncing ones.
- Passes `allow` through as a gate: the conditioner emits nothing while `allow` is low.

---
 rtl/x_cond_pkg.sv | 9 +
 rtl/x_input_conditioner_sync_chain.sv | 23 ++
 rtl/x_input_conditioner.sv | 106 ++++++++++
 tb/tb_x_input_conditioner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/x_cond_pkg.sv
// rtl/x_cond_pkg.sv - shared state encoding and default parameters for the input conditioner
package x_cond_pkg;

    typedef enum logic [1:0] {IDLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW} xc_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/x_input_conditioner_sync_chain.sv
// rtl/x_input_conditioner_sync_chain.sv - multi-flop synchronizer for the raw button input
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/x_input_conditioner.sv
// rtl/x_input_conditioner.sv - synchronize, debounce and shape btn_raw into x; X_PULSE_MODE_EN makes x a one-clock rise pulse
module x_input_conditioner
    import x_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic allow,
    input  logic btn_raw,
    output logic x,
    output logic x_level,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    xc_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;

    // The synchronizer ignores allow so s is already settled when allow rises.
    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_raw),
        .q    (s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !allow) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            level_q <= 1'b0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= CHK_HIGH;
                        cnt   <= '0;
                    end
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STABLE_HIGH;
                        level_q <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state <= CHK_LOW;
                        cnt   <= '0;
                    end
                end
                CHK_LOW: begin
                    if (s) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE_LOW;
                        level_q <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign x_level = level_q;
    assign busy    = (state == CHK_HIGH) || (state == CHK_LOW);

`ifdef X_PULSE_MODE_EN
    logic pulse_q;

    // Fires on the same edge that commits the rising level, never on the fall.
    always_ff @(posedge clk) begin
        if (!rst_n || !allow) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= (state == CHK_HIGH) && s && (cnt == CNT_LAST);
        end
    end

    assign x = pulse_q;
`else
    assign x = level_q;
`endif

endmodule

// File: tb/tb_x_input_conditioner.sv
// tb/tb_x_input_conditioner.sv - scoreboard bench for x_input_conditioner
module tb_x_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic allow = 1'b1;
    logic btn_raw = 1'b1;
    logic x, x_level, busy;

    int checks = 0;
    int errors = 0;

    x_input_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .allow  (allow),
        .btn_raw(btn_raw),
        .x      (x),
        .x_level(x_level),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: level flips once the synchronized input has disagreed with it
    // on DEB+1 consecutive FSM edges; busy while a disagreement run is open.
    logic [SYNC-1:0] m_pipe;
    logic            m_lvl;
    int              m_run;
    logic            m_pulse;
    logic            m_s;
    logic [2:0]      exp_q[$];

    always @(posedge clk) begin
        m_s = m_pipe[SYNC-1];
        if (!rst_n) begin
            m_pipe  = '0;
            m_lvl   = 1'b0;
            m_run   = 0;
            m_pulse = 1'b0;
        end else begin
            m_pipe  = {m_pipe[SYNC-2:0], btn_raw};
            m_pulse = 1'b0;
            if (!allow) begin
                m_lvl = 1'b0;
                m_run = 0;
            end else if (m_s != m_lvl) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_pulse = !m_lvl;
                    m_lvl   = !m_lvl;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
`ifdef X_PULSE_MODE_EN
        exp_q.push_back({m_pulse, m_lvl, (m_run != 0)});
`else
        exp_q.push_back({m_lvl, m_lvl, (m_run != 0)});
`endif
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("x", int'(x), int'(e[2]));
            check("x_level", int'(x_level), int'(e[1]));
            check("busy", int'(busy), int'(e[0]));
        end
    end

    // Count edges from now until x_level reaches target; 0 if it never does.
    task automatic measure(input logic target, input int maxc, output int lat);
        lat = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk);
            #1;
            if (x_level == target && lat == 0) lat = i;
        end
        @(negedge clk);
    endtask

    task automatic hold(input logic b, input int n);
        btn_raw = b;
        repeat (n) @(negedge clk);
    endtask

    int lat;
    logic [6:0] bounce;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        measure(1'b1, 10, lat);
        check("rise_latency", lat, SYNC + DEB + 1);
        btn_raw = 1'b0;
        measure(1'b0, 10, lat);
        check("fall_latency", lat, SYNC + DEB + 1);

        bounce = 7'b1110110;
        for (int i = 6; i >= 0; i--) hold(bounce[i], 1);
        hold(1'b0, 6);
        check("bounce_level", int'(x_level), 0);

        hold(1'b1, DEB);
        hold(1'b0, 8);
        check("short_pulse_level", int'(x_level), 0);

        allow = 1'b0;
        hold(1'b1, 20);
        check("gated_x", int'(x), 0);
        allow = 1'b1;
        measure(1'b1, 10, lat);
        check("allow_latency", lat, DEB + 1);
        hold(1'b0, 10);

        hold(1'b1, 5);
        check("mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_busy_after", int'(busy), 0);
        hold(1'b0, 10);

        for (int k = 0; k < 60; k++) begin
            allow = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 29) != 0);
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        rst_n = 1'b1;
        allow = 1'b1;
        hold(1'b0, 12);
        check("final_level", int'(x_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
